// File: rtl/lcd_spi_rx_decoder.sv
// Responder for the 4-wire LCD SPI link: it oversamples CS/SCL/MOSI/DC and decodes commands, parameters and RGB565 pixels.
// Defining LCD_SPI_RX_CHECKSUM_EN builds the running pixel checksum on pix_sum. Without it, pix_sum is constant 0.
module lcd_spi_rx_decoder #(
   parameter int H_RES = 160,
   parameter int V_RES = 80,
   parameter int X_W   = 8,
   parameter int Y_W   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cs,
   input  logic           scl,
   input  logic           mosi,
   input  logic           dc,
   output logic           cmd_valid,
   output logic [7:0]     cmd_byte,
   output logic           prm_valid,
   output logic [7:0]     prm_byte,
   output logic           pix_valid,
   output logic [X_W-1:0] pix_x,
   output logic [Y_W-1:0] pix_y,
   output logic [15:0]    pix_rgb,
   output logic           frame_done,
   output logic [2:0]     status,
   output logic [15:0]    pix_sum
);

   typedef enum logic [2:0] {IDLE, S_PRM, S_CASET, S_RASET, S_PIX_HI, S_PIX_LO} state_t;

   state_t         state, state_next;
   logic [1:0]     cs_sync, mosi_sync, dc_sync;
   logic [2:0]     scl_sync;
   logic           scl_rise;
   logic [2:0]     bit_cnt;
   logic [6:0]     shift;
   logic           byte_strobe, byte_dc;
   logic [7:0]     byte_data;
   logic [1:0]     win_cnt;
   logic [7:0]     win_b0, win_b1, win_b2;
   logic [7:0]     pix_hi;
   logic [X_W-1:0] xs, xe, px;
   logic [Y_W-1:0] ys, ye, py;
   logic           sleep_out, inv_on, disp_on;
   logic           cmd_fire, prm_fire, hi_fire, pix_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync   <= 2'b11;
         scl_sync  <= '0;
         mosi_sync <= '0;
         dc_sync   <= '0;
      end else begin
         cs_sync   <= {cs_sync[0], cs};
         scl_sync  <= {scl_sync[1:0], scl};
         mosi_sync <= {mosi_sync[0], mosi};
         dc_sync   <= {dc_sync[0], dc};
      end
   end

   assign scl_rise = scl_sync[1] & ~scl_sync[2];

   // Deasserting CS drops any partial byte. A byte completes on its 8th edge, and DC is latched on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         shift       <= '0;
         byte_strobe <= 1'b0;
         byte_dc     <= 1'b0;
         byte_data   <= '0;
      end else begin
         byte_strobe <= 1'b0;
         if (cs_sync[1]) begin
            bit_cnt <= '0;
         end else if (scl_rise) begin
            shift   <= {shift[5:0], mosi_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_data   <= {shift, mosi_sync[1]};
               byte_dc     <= dc_sync[1];
               byte_strobe <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_fire   = 1'b0;
      prm_fire   = 1'b0;
      hi_fire    = 1'b0;
      pix_fire   = 1'b0;
      if (byte_strobe) begin
         if (!byte_dc) begin
            cmd_fire = 1'b1;
            case (byte_data)
               8'h2A:   state_next = S_CASET;
               8'h2B:   state_next = S_RASET;
               8'h2C:   state_next = S_PIX_HI;
               default: state_next = S_PRM;
            endcase
         end else begin
            case (state)
               S_PRM: prm_fire = 1'b1;
               S_CASET, S_RASET: begin
                  prm_fire = 1'b1;
                  if (win_cnt == 2'd3) state_next = S_PRM;
               end
               S_PIX_HI: begin
                  hi_fire    = 1'b1;
                  state_next = S_PIX_LO;
               end
               S_PIX_LO: begin
                  pix_fire   = 1'b1;
                  state_next = S_PIX_HI;
               end
               default: ;
            endcase
         end
      end
   end

   // A command restarts window collection. The 4th window byte commits start and end together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid  <= 1'b0;
         cmd_byte   <= '0;
         prm_valid  <= 1'b0;
         prm_byte   <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_rgb    <= '0;
         frame_done <= 1'b0;
         sleep_out  <= 1'b0;
         inv_on     <= 1'b0;
         disp_on    <= 1'b0;
         win_cnt    <= '0;
         win_b0     <= '0;
         win_b1     <= '0;
         win_b2     <= '0;
         pix_hi     <= '0;
         xs         <= '0;
         xe         <= X_W'(H_RES - 1);
         ys         <= '0;
         ye         <= Y_W'(V_RES - 1);
         px         <= '0;
         py         <= '0;
      end else begin
         cmd_valid  <= cmd_fire;
         prm_valid  <= prm_fire;
         pix_valid  <= pix_fire;
         frame_done <= pix_fire && (px == xe) && (py == ye);
         if (cmd_fire) begin
            cmd_byte <= byte_data;
            win_cnt  <= '0;
            case (byte_data)
               8'h10:   sleep_out <= 1'b0;
               8'h11:   sleep_out <= 1'b1;
               8'h20:   inv_on    <= 1'b0;
               8'h21:   inv_on    <= 1'b1;
               8'h28:   disp_on   <= 1'b0;
               8'h29:   disp_on   <= 1'b1;
               8'h2C: begin
                  px <= xs;
                  py <= ys;
               end
               default: ;
            endcase
         end
         if (prm_fire) begin
            prm_byte <= byte_data;
            if (state == S_CASET || state == S_RASET) begin
               win_cnt <= win_cnt + 2'd1;
               case (win_cnt)
                  2'd0: win_b0 <= byte_data;
                  2'd1: win_b1 <= byte_data;
                  2'd2: win_b2 <= byte_data;
                  default: begin
                     if (state == S_CASET) begin
                        xs <= X_W'({win_b0, win_b1});
                        xe <= X_W'({win_b2, byte_data});
                     end else begin
                        ys <= Y_W'({win_b0, win_b1});
                        ye <= Y_W'({win_b2, byte_data});
                     end
                  end
               endcase
            end
         end
         if (hi_fire) pix_hi <= byte_data;
         if (pix_fire) begin
            pix_rgb <= {pix_hi, byte_data};
            pix_x   <= px;
            pix_y   <= py;
            if (px == xe) begin
               px <= xs;
               py <= (py == ye) ? ys : py + Y_W'(1);
            end else begin
               px <= px + X_W'(1);
            end
         end
      end
   end

   assign status = {disp_on, inv_on, sleep_out};

`ifdef LCD_SPI_RX_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            pix_sum <= '0;
      else if (cmd_fire && byte_data == 8'h2C) pix_sum <= '0;
      else if (pix_fire)                     pix_sum <= pix_sum + {pix_hi, byte_data};
   end
`else
   assign pix_sum = 16'd0;
`endif

endmodule
